// File: rtl/glitc_config_sequencer_if.sv
// Wishbone slave bus between the TISC host and the GLITC configuration sequencer.
interface glitc_config_sequencer_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o, rty_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/glitc_config_sequencer.sv
// Per-GLITC PROGRAM_B/INIT_B sequencer producing gready for the GLITCBUS master.
// Optional macro GLITC_CONFIG_LOAD_TIMEOUT_EN bounds LOAD to LOAD_TIMEOUT_CYCLES.
module glitc_config_sequencer #(
    parameter int unsigned PROG_PULSE_CYCLES   = 100,
    parameter int unsigned INIT_HOLD_CYCLES    = 64,
    parameter int unsigned INIT_TIMEOUT_CYCLES = 65536,
    parameter int unsigned STARTUP_CYCLES      = 16,
    parameter int unsigned LOAD_TIMEOUT_CYCLES = 16777215
) (
    input  logic                           clk_i,
    input  logic                           rst_b_i,
    glitc_config_sequencer_if.slave        wb,
    output logic [3:0]                     PROGRAM_B,
    output logic [3:0]                     INIT_B_OE,
    input  logic [3:0]                     INIT_B_IN,
    input  logic [3:0]                     DONE,
    output logic [3:0]                     gready_o
);
    localparam int unsigned N_GLITC = 4;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned DATA_W  = 32;

    // Counters hold "cycles remaining minus one", so a state loaded with C lasts C cycles.
    localparam logic [CNT_W-1:0] PROG_LD    = CNT_W'(PROG_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(INIT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INITTO_LD  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LD    = CNT_W'(LOAD_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_UNCONFIG  = 3'd0,
        ST_PROG      = 3'd1,
        ST_INIT_HOLD = 3'd2,
        ST_INIT_WAIT = 3'd3,
        ST_LOAD      = 3'd4,
        ST_STARTUP   = 3'd5,
        ST_READY     = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    state_e                 state_q [N_GLITC];
    state_e                 state_d [N_GLITC];
    logic [CNT_W-1:0]       cnt_q   [N_GLITC];
    logic [CNT_W-1:0]       cnt_d   [N_GLITC];
    logic [N_GLITC-1:0]     done_m_q, done_s_q, init_m_q, init_s_q;
    logic [N_GLITC-1:0]     err_q, err_d, cause_q, cause_d;
    logic [N_GLITC-1:0]     prog_b_q, init_oe_q, gready_q;
    logic                   ack_q;
    logic [DATA_W-1:0]      dat_q;
    logic                   wb_acc_c, cmd_wr_c, st_rd_c;
    logic [N_GLITC-1:0]     start_c, abort_c;
    logic [DATA_W-1:0]      status_c;
    logic                   unused_ok;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
    logic [N_GLITC-1:0]     lt_q, lt_d;
`endif

    // Wishbone decode; an ack cycle blocks acceptance so strobes ack every other cycle.
    assign wb_acc_c = wb.cyc_i & wb.stb_i & ~ack_q;
    assign cmd_wr_c = wb_acc_c & wb.we_i & (wb.adr_i[3:2] == 2'd0);
    assign st_rd_c  = wb_acc_c & ~wb.we_i & (wb.adr_i[3:2] == 2'd1);
    assign start_c  = cmd_wr_c ? wb.dat_i[3:0]  : '0;
    assign abort_c  = cmd_wr_c ? wb.dat_i[11:8] : '0;

    always_comb begin
        status_c        = '0;
        status_c[3:0]   = gready_q;
        status_c[7:4]   = done_s_q;
        status_c[11:8]  = init_s_q;
        status_c[15:12] = err_q;
        status_c[19:16] = cause_q;
        status_c[22:20] = state_q[0];
        status_c[25:23] = state_q[1];
        status_c[28:26] = state_q[2];
        status_c[30:29] = 2'(state_q[3]);
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
        status_c[31]    = |lt_q;
`endif
    end

    // Next-state logic, one FSM per GLITC; ABORT beats START for the same GLITC.
    always_comb begin
        err_d   = err_q;
        cause_d = cause_q;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
        lt_d    = lt_q;
`endif
        for (int g = 0; g < N_GLITC; g++) begin
            state_d[g] = state_q[g];
            cnt_d[g]   = (cnt_q[g] != '0) ? cnt_q[g] - CNT_W'(1) : cnt_q[g];
            unique case (state_q[g])
                ST_UNCONFIG: if (done_s_q[g]) begin
                    state_d[g] = ST_STARTUP;
                    cnt_d[g]   = STARTUP_LD;
                end
                ST_PROG: if (cnt_q[g] == '0) begin
                    state_d[g] = ST_INIT_HOLD;
                    cnt_d[g]   = HOLD_LD;
                end
                ST_INIT_HOLD: if (cnt_q[g] == '0) begin
                    state_d[g] = ST_INIT_WAIT;
                    cnt_d[g]   = INITTO_LD;
                end
                ST_INIT_WAIT: if (init_s_q[g]) begin
                    state_d[g] = ST_LOAD;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
                    cnt_d[g]   = LOAD_LD;
`endif
                end else if (cnt_q[g] == '0) begin
                    state_d[g] = ST_ERROR;
                    err_d[g]   = 1'b1;
                    cause_d[g] = 1'b0;
                end
                ST_LOAD: if (done_s_q[g]) begin
                    state_d[g] = ST_STARTUP;
                    cnt_d[g]   = STARTUP_LD;
                end else if (!init_s_q[g]) begin
                    state_d[g] = ST_ERROR;
                    err_d[g]   = 1'b1;
                    cause_d[g] = 1'b1;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
                end else if (cnt_q[g] == '0) begin
                    state_d[g] = ST_ERROR;
                    err_d[g]   = 1'b1;
                    cause_d[g] = 1'b0;
                    lt_d[g]    = 1'b1;
`endif
                end
                ST_STARTUP: if (!done_s_q[g]) begin
                    state_d[g] = ST_LOAD;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
                    cnt_d[g]   = LOAD_LD;
`endif
                end else if (cnt_q[g] == '0) begin
                    state_d[g] = ST_READY;
                end
                ST_READY: if (!done_s_q[g]) state_d[g] = ST_UNCONFIG;
                ST_ERROR: ;
            endcase
            if (abort_c[g] || start_c[g]) begin
                err_d[g]   = 1'b0;
                cause_d[g] = 1'b0;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
                lt_d[g]    = 1'b0;
`endif
                if (abort_c[g]) begin
                    state_d[g] = ST_UNCONFIG;
                end else begin
                    state_d[g] = ST_PROG;
                    cnt_d[g]   = PROG_LD;
                end
            end
        end
    end

    // State, counters, synchronizers and pin drivers decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            done_m_q  <= '0;
            done_s_q  <= '0;
            init_m_q  <= '0;
            init_s_q  <= '0;
            err_q     <= '0;
            cause_q   <= '0;
            prog_b_q  <= '1;
            init_oe_q <= '0;
            gready_q  <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
            lt_q      <= '0;
`endif
            for (int g = 0; g < N_GLITC; g++) begin
                state_q[g] <= ST_UNCONFIG;
                cnt_q[g]   <= '0;
            end
        end else begin
            done_m_q  <= DONE;
            done_s_q  <= done_m_q;
            init_m_q  <= INIT_B_IN;
            init_s_q  <= init_m_q;
            err_q     <= err_d;
            cause_q   <= cause_d;
            ack_q     <= wb_acc_c;
            dat_q     <= st_rd_c ? status_c : '0;
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
            lt_q      <= lt_d;
`endif
            for (int g = 0; g < N_GLITC; g++) begin
                state_q[g]   <= state_d[g];
                cnt_q[g]     <= cnt_d[g];
                prog_b_q[g]  <= (state_d[g] != ST_PROG);
                init_oe_q[g] <= (state_d[g] == ST_PROG) || (state_d[g] == ST_INIT_HOLD);
                gready_q[g]  <= (state_d[g] == ST_READY);
            end
        end
    end

    assign PROGRAM_B = prog_b_q;
    assign INIT_B_OE = init_oe_q;
    assign gready_o  = gready_q;
    assign wb.ack_o  = ack_q;
    assign wb.dat_o  = dat_q;
    assign wb.err_o  = 1'b0;
    assign wb.rty_o  = 1'b0;

`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
    assign unused_ok = ^{wb.sel_i, wb.adr_i[1:0], wb.dat_i[31:12], wb.dat_i[7:4]};
`else
    assign unused_ok = ^{wb.sel_i, wb.adr_i[1:0], wb.dat_i[31:12], wb.dat_i[7:4], LOAD_LD};
`endif
endmodule

// File: tb/tb_glitc_config_sequencer.sv
// Bench for glitc_config_sequencer: directed plan scenarios plus random traffic against a
// cycle-level behavioural model of the per-GLITC configuration flow.
`timescale 1ns/1ps
module tb_glitc_config_sequencer;
    localparam int unsigned PROG_C   = 100;
    localparam int unsigned HOLD_C   = 64;
    localparam int unsigned INITTO_C = 65536;
    localparam int unsigned START_C  = 16;
    localparam int unsigned LOADTO_C = 1000;
    localparam int UNCONFIG = 0, PROG = 1, HOLD = 2, IWAIT = 3, LOAD = 4, STARTUP = 5,
                   READY = 6, ERROR = 7;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  prog_b, init_oe, init_b_in, done, gready, ext_init;
    glitc_config_sequencer_if bus ();

    // INIT_B is open drain: the pad is low when either side pulls it.
    assign init_b_in = ext_init & ~init_oe;
    always #5 clk = ~clk;

    glitc_config_sequencer #(
        .PROG_PULSE_CYCLES  (PROG_C),
        .INIT_HOLD_CYCLES   (HOLD_C),
        .INIT_TIMEOUT_CYCLES(INITTO_C),
        .STARTUP_CYCLES     (START_C),
        .LOAD_TIMEOUT_CYCLES(LOADTO_C)
    ) dut (
        .clk_i    (clk),
        .rst_b_i  (rst_b),
        .wb       (bus),
        .PROGRAM_B(prog_b),
        .INIT_B_OE(init_oe),
        .INIT_B_IN(init_b_in),
        .DONE     (done),
        .gready_o (gready)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    int        m_st  [4];
    int        m_rem [4];
    bit [3:0]  m_err, m_cause, m_lt, m_dm, m_ds, m_im, m_is, m_oe, m_progb, m_gready;
    bit        m_ack;
    bit [31:0] m_dat;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_status();
        bit [31:0] s;
        s = '0;
        for (int g = 0; g < 4; g++) s[g] = (m_st[g] == READY);
        s[7:4]   = m_ds;
        s[11:8]  = m_is;
        s[15:12] = m_err;
        s[19:16] = m_cause;
        s[22:20] = 3'(m_st[0]);
        s[25:23] = 3'(m_st[1]);
        s[28:26] = 3'(m_st[2]);
        s[30:29] = 2'(m_st[3] % 4);
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
        s[31]    = |m_lt;
`endif
        return s;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_st[g]  = UNCONFIG;
            m_rem[g] = 0;
        end
        {m_err, m_cause, m_lt, m_dm, m_ds, m_im, m_is, m_oe, m_gready} = '0;
        m_progb = 4'hF;
        m_ack   = 1'b0;
        m_dat   = '0;
    endtask

    // Advance the model by one clock edge using the stimulus currently applied.
    task automatic model_edge();
        bit       acc, cmd;
        bit [3:0] st_m, ab_m, ipin;
        int       ns, nr;
        bit       d, i;
        if (!rst_b) begin
            model_reset();
            return;
        end
        acc  = bus.cyc_i && bus.stb_i && !m_ack;
        cmd  = acc && bus.we_i && (bus.adr_i[3:2] == 2'd0);
        m_dat = (acc && !bus.we_i && bus.adr_i[3:2] == 2'd1) ? m_status() : 32'h0;
        st_m = cmd ? bus.dat_i[3:0]  : 4'h0;
        ab_m = cmd ? bus.dat_i[11:8] : 4'h0;
        ipin = ext_init & ~m_oe;
        for (int g = 0; g < 4; g++) begin
            ns = m_st[g];
            nr = m_rem[g] - 1;
            d  = m_ds[g];
            i  = m_is[g];
            case (m_st[g])
                UNCONFIG: if (d) begin ns = STARTUP; nr = START_C; end
                PROG:     if (m_rem[g] == 1) begin ns = HOLD; nr = HOLD_C; end
                HOLD:     if (m_rem[g] == 1) begin ns = IWAIT; nr = INITTO_C; end
                IWAIT: begin
                    if (i) begin ns = LOAD; nr = LOADTO_C; end
                    else if (m_rem[g] == 1) begin ns = ERROR; m_err[g] = 1; m_cause[g] = 0; end
                end
                LOAD: begin
                    if (d) begin ns = STARTUP; nr = START_C; end
                    else if (!i) begin ns = ERROR; m_err[g] = 1; m_cause[g] = 1; end
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
                    else if (m_rem[g] == 1) begin
                        ns = ERROR; m_err[g] = 1; m_cause[g] = 0; m_lt[g] = 1;
                    end
`endif
                end
                STARTUP: begin
                    if (!d) begin ns = LOAD; nr = LOADTO_C; end
                    else if (m_rem[g] == 1) ns = READY;
                end
                READY:   if (!d) ns = UNCONFIG;
                default: ;
            endcase
            if (ab_m[g] || st_m[g]) begin
                m_err[g] = 0; m_cause[g] = 0; m_lt[g] = 0;
                if (ab_m[g]) ns = UNCONFIG;
                else begin ns = PROG; nr = PROG_C; end
            end
            m_st[g]     = ns;
            m_rem[g]    = nr;
            m_progb[g]  = (ns != PROG);
            m_oe[g]     = (ns == PROG) || (ns == HOLD);
            m_gready[g] = (ns == READY);
        end
        m_ds  = m_dm;
        m_dm  = done;
        m_is  = m_im;
        m_im  = ipin;
        m_ack = acc;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("pins", {19'h0, prog_b, init_oe, gready, bus.ack_o},
                 {19'h0, m_progb, m_oe, m_gready, m_ack});
        if (m_ack) check_eq("rdata", bus.dat_o, m_dat);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wb_idle();
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] d);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = adr; bus.dat_i = d;
        step();
        wb_idle();
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] d);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = adr; bus.dat_i = '0;
        step();
        d = bus.dat_o;
        wb_idle();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int          n, acks;
        rst_b = 0; done = 0; ext_init = 4'hF;
        bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = 4'hF;
        wb_idle();
        model_reset();

        // Reset values
        steps(4);
        check_eq("rst_pins", {prog_b, init_oe, gready}, 12'hF00);
        check_eq("rst_errrty", {bus.err_o, bus.rty_o}, 0);
        rst_b = 1;
        steps(3);
        wb_read(4'h4, s);
        check_eq("rst_status", s, 32'h0000_0F00);
        step();

        // Full configuration of GLITC0
        wb_write(4'h0, 32'h1);
        n = 0;
        while (prog_b[0] == 1'b0 && n < 300) begin step(); n++; end
        check_eq("prog_len", n, PROG_C);
        n = 0;
        while (init_oe[0] == 1'b1 && n < 300) begin step(); n++; end
        check_eq("hold_len", n, HOLD_C);
        steps(9);
        wb_read(4'h4, s);
        check_eq("load_state", s[22:20], LOAD);
        step();
        done[0] = 1;
        n = 0;
        while (gready[0] == 1'b0 && n < 100) begin step(); n++; end
        check_eq("gready_lat", n, 2 + 1 + START_C);

        // CRC error in LOAD
        done[0] = 0;
        steps(4);
        wb_write(4'h0, 32'h1);
        steps(180);
        wb_read(4'h4, s);
        check_eq("crc_pre", s[22:20], LOAD);
        step();
        ext_init[0] = 0;
        steps(5);
        wb_read(4'h4, s);
        check_eq("crc_state", s[22:20], ERROR);
        check_eq("crc_flags", {s[12], s[16]}, 2'b11);
        check_eq("crc_gready", gready[0], 0);

        // INIT_B held low: timeout exactly INITTO_C cycles after INIT_WAIT entry
        step();
        wb_write(4'h0, 32'h1);
        steps(PROG_C + HOLD_C);
        steps(INITTO_C - 2);
        wb_read(4'h4, s);
        check_eq("to_not_yet", s[22:20], IWAIT);
        step();
        wb_read(4'h4, s);
        check_eq("to_state", s[22:20], ERROR);
        check_eq("to_flags", {s[12], s[16]}, 2'b10);
        step();
        wb_write(4'h0, 32'h100);
        step();
        wb_read(4'h4, s);
        check_eq("abort_clr", {s[22:20], s[12], s[16]}, 0);
        ext_init[0] = 1;

        // ABORT beats START; starting another GLITC leaves gready alone
        step();
        wb_write(4'h0, 32'h0F0F);
        check_eq("abort_wins", prog_b, 4'hF);
        steps(3);
        wb_read(4'h4, s);
        check_eq("abort_states", s[30:20], 0);
        done[0] = 1;
        steps(25);
        check_eq("ready0", gready, 4'h1);
        wb_write(4'h0, 32'h4);
        check_eq("start2_gready", gready, 4'h1);
        steps(50);
        check_eq("start2_pins", {prog_b, gready}, 8'hB1);

        // Back-to-back strobes ack every other cycle
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 4'h8;
        acks = 0;
        for (int k = 0; k < 4; k++) begin step(); acks += int'(bus.ack_o); end
        wb_idle();
        check_eq("b2b_acks", acks, 2);

        // LOAD with DONE never rising
        step();
        wb_write(4'h0, 32'h2);
        steps(1300);
        wb_read(4'h4, s);
`ifdef GLITC_CONFIG_LOAD_TIMEOUT_EN
        check_eq("ldto_state", s[25:23], ERROR);
        check_eq("ldto_flags", {s[31], s[13], s[17]}, 3'b110);
`else
        check_eq("ld_wait_state", s[25:23], LOAD);
        check_eq("ld_bit31", s[31], 0);
`endif

        // Reset mid-operation releases the pins
        step();
        wb_write(4'h0, 32'h8);
        steps(20);
        rst_b = 0;
        step();
        check_eq("midrst_pins", {prog_b, init_oe, gready}, 12'hF00);
        steps(2);
        rst_b = 1;
        steps(5);

        // Random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            if (bus.stb_i) begin
                wb_idle();
            end else if ($urandom_range(0, 39) == 0) begin
                bus.cyc_i = 1; bus.stb_i = 1;
                bus.we_i  = ($urandom_range(0, 3) == 0);
                bus.adr_i = 4'($urandom);
                s = $urandom;
                s[3:0]  = s[3:0] & 4'($urandom);
                s[11:8] = s[11:8] & 4'($urandom) & 4'($urandom);
                bus.dat_i = s;
            end
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 299) == 0) done[g] = ~done[g];
                if (ext_init[g]) begin
                    if ($urandom_range(0, 1999) == 0) ext_init[g] = 0;
                end else if ($urandom_range(0, 19) == 0) begin
                    ext_init[g] = 1;
                end
            end
            step();
        end
        wb_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
